// File: rtl/risc_core.sv
// Single-cycle 16-bit RISC core: fetch, execute and commit one instruction per rising edge.
// Program, data and registers are preloaded hierarchically; there is no external data path.

module risc_pc #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_out
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_out <= '0;
    end else if (hold) begin
      pc_out <= pc_out;
    end else if (jump) begin
      pc_out <= target;
    end else begin
      pc_out <= pc_out + ADDR_W'(1);
    end
  end
endmodule

module risc_rom #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] data
);
  logic [INSTR_W-1:0] memory [0:(1<<ADDR_W)-1];

  // Load port is for a boot loader; in this core it is tied off and contents arrive by preload.
  always_ff @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign data = memory[addr];
endmodule

module risc_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [0:7];

  always_ff @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

module risc_sram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] memory [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module risc_alu #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               reg_we,
  output logic [DATA_W-1:0]  result,
  output logic               mem_we,
  output logic               jump,
  output logic               halt
);
  logic [6:0] opcode;
  assign opcode = instr[15:9];

  // Unknown or X opcodes fall to default, so garbage fetches never enable a write.
  always_comb begin
    reg_we = 1'b0;
    result = '0;
    mem_we = 1'b0;
    jump   = 1'b0;
    halt   = 1'b0;
    case (opcode)
      7'd1:  halt = 1'b1;
      7'd2:  begin reg_we = 1'b1; result = a + b; end
      7'd3:  begin reg_we = 1'b1; result = a - b; end
      7'd4:  begin reg_we = 1'b1; result = a & b; end
      7'd5:  begin reg_we = 1'b1; result = a | b; end
      7'd6:  begin reg_we = 1'b1; result = a ^ b; end
      7'd7:  begin reg_we = 1'b1; result = mem_data; end
      7'd8:  mem_we = 1'b1;
      7'd9:  begin reg_we = 1'b1; result = {{(DATA_W-6){1'b0}}, instr[5:0]}; end
      7'd10: jump = 1'b1;
      7'd11: jump = (a == '0);
      default: ;
    endcase
  end
endmodule

module risc_core #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 10
) (
  input logic clk,
  input logic rstn
);
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  src_a, src_b, mem_data, result;
  logic               reg_we, mem_we, jump, halt, halted, commit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     halted <= 1'b0;
    else if (halt) halted <= 1'b1;
  end

  // Nothing commits while reset is held or once the core has halted.
  assign commit = rstn & ~halted;

  risc_pc #(.ADDR_W(ADDR_W)) pc0 (
    .clk    (clk),
    .rstn   (rstn),
    .hold   (halt | halted),
    .jump   (jump),
    .target (src_b[ADDR_W-1:0]),
    .pc_out (pc)
  );

  risc_rom #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) rom0 (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (pc),
    .data      (instr)
  );

  risc_regfile #(.DATA_W(DATA_W)) registers0 (
    .clk     (clk),
    .we      (reg_we & commit),
    .waddr   (instr[8:6]),
    .wdata   (result),
    .raddr_a (instr[5:3]),
    .raddr_b (instr[2:0]),
    .rdata_a (src_a),
    .rdata_b (src_b)
  );

  risc_alu #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) alu0 (
    .instr    (instr),
    .a        (src_a),
    .b        (src_b),
    .mem_data (mem_data),
    .reg_we   (reg_we),
    .result   (result),
    .mem_we   (mem_we),
    .jump     (jump),
    .halt     (halt)
  );

  risc_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram0 (
    .clk   (clk),
    .we    (mem_we & commit),
    .addr  (src_b[ADDR_W-1:0]),
    .wdata (src_a),
    .rdata (mem_data)
  );
endmodule

// File: tb/tb_risc_core.sv
// Bench for risc_core: directed programs plus random programs checked against an
// instruction-level reference model of the ISA.
module tb_risc_core;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_sram [1024];
  logic [15:0] m_rom  [1024];
  int          m_pc;
  bit          m_halted;

  risc_core dut (.clk(clk), .rstn(rstn));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
    return 16'((op << 9) | (d << 6) | (a << 3) | b);
  endfunction

  task automatic set_rom(input int addr, input logic [15:0] w);
    m_rom[addr] = w;
    dut.rom0.memory[addr] = w;
  endtask

  task automatic set_reg(input int idx, input logic [15:0] v);
    m_regs[idx] = v;
    dut.registers0.regs[idx] = v;
  endtask

  task automatic set_sram(input int addr, input logic [15:0] v);
    m_sram[addr] = v;
    dut.sram0.memory[addr] = v;
  endtask

  task automatic set_pc(input int p);
    m_pc = p;
    dut.pc0.pc_out = 10'(p);
  endtask

  // One architectural instruction, computed with plain integer arithmetic.
  task automatic model_step();
    logic [15:0] ins;
    int op, d, a, b, ra, rb, next;
    if (m_halted) return;
    ins  = m_rom[m_pc];
    op   = int'(ins) / 512;
    d    = (int'(ins) / 64) % 8;
    a    = (int'(ins) / 8) % 8;
    b    = int'(ins) % 8;
    ra   = int'(m_regs[a]);
    rb   = int'(m_regs[b]);
    next = (m_pc + 1) % 1024;
    case (op)
      1:  begin m_halted = 1'b1; next = m_pc; end
      2:  m_regs[d] = 16'((ra + rb) % 65536);
      3:  m_regs[d] = 16'((ra - rb + 65536) % 65536);
      4:  m_regs[d] = 16'(ra & rb);
      5:  m_regs[d] = 16'(ra | rb);
      6:  m_regs[d] = 16'(ra ^ rb);
      7:  m_regs[d] = m_sram[rb % 1024];
      8:  m_sram[rb % 1024] = 16'(ra);
      9:  m_regs[d] = 16'(int'(ins) % 64);
      10: next = rb % 1024;
      11: if (ra == 0) next = rb % 1024;
      default: ;
    endcase
    m_pc = next;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, 32'(dut.pc0.pc_out), 32'(m_pc));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut.registers0.regs[i]), 32'(m_regs[i]));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (rstn) model_step();
      #1;
      check_state(tag);
    end
  endtask

  task automatic setup_plan();
    for (int i = 0; i < 1024; i++) begin
      set_rom(i, 16'h0000);
      set_sram(i, 16'h0000);
    end
    for (int i = 0; i < 8; i++) set_reg(i, 16'(i + 1));
    for (int i = 0; i < 7; i++) set_sram(i, 16'(10 * i));
    set_pc(0);
    m_halted = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    m_pc = 0;
    m_halted = 1'b0;
    #1 check({tag, "_pc_async"}, 32'(dut.pc0.pc_out), 32'd0);
    @(posedge clk);
    #1 check_state({tag, "_held"});
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Basic ADD program, reset never driven low.
    setup_plan();
    set_rom(1, enc(2, 0, 1, 2));
    set_rom(2, enc(2, 3, 4, 5));
    run(8, "add");
    check("add_r0", 32'(dut.registers0.regs[0]), 32'd5);
    check("add_r3", 32'(dut.registers0.regs[3]), 32'd11);
    check("add_pc", 32'(dut.pc0.pc_out), 32'd8);
    for (int i = 0; i < 7; i++)
      check($sformatf("add_sram%0d", i), 32'(dut.sram0.memory[i]), 32'(10 * i));

    // Memory, arithmetic wrap and control flow.
    @(negedge clk);
    setup_plan();
    set_rom(0,  enc(7, 6, 0, 2));
    set_rom(1,  enc(8, 0, 6, 1));
    set_rom(2,  enc(7, 5, 0, 1));
    set_rom(3,  enc(3, 0, 1, 2));
    set_rom(4,  enc(6, 0, 0, 0));
    set_rom(5,  enc(9, 4, 7, 7));
    set_rom(6,  enc(10, 0, 0, 7));
    set_rom(8,  enc(9, 2, 2, 4));
    set_rom(9,  enc(11, 0, 0, 2));
    set_rom(20, enc(9, 3, 0, 5));
    set_rom(21, enc(11, 0, 3, 2));
    set_rom(22, enc(1, 0, 0, 0));
    run(1, "ld");    check("load_r6", 32'(dut.registers0.regs[6]), 32'd30);
    run(1, "st");    check("store_sram2", 32'(dut.sram0.memory[2]), 32'd30);
    run(1, "ld2");   check("reload_r5", 32'(dut.registers0.regs[5]), 32'd30);
    run(1, "sub");   check("sub_wrap_r0", 32'(dut.registers0.regs[0]), 32'hFFFF);
    run(1, "xor");   check("xor_self_r0", 32'(dut.registers0.regs[0]), 32'd0);
    run(1, "ldc");   check("loadc_r4", 32'(dut.registers0.regs[4]), 32'd63);
    run(1, "jmp");   check("jmp_pc", 32'(dut.pc0.pc_out), 32'd8);
    run(1, "ldc2");
    run(1, "jz_t");  check("jz_taken_pc", 32'(dut.pc0.pc_out), 32'd20);
    run(1, "ldc3");
    run(1, "jz_nt"); check("jz_fall_pc", 32'(dut.pc0.pc_out), 32'd22);
    run(11, "halt"); check("halt_pc", 32'(dut.pc0.pc_out), 32'd22);

    // Reset out of halt; ROM[0] (LOAD R6 from sram[R2=20]) must not commit while held.
    async_reset_check("rst_halt");
    run(1, "restart");
    check("restart_r6", 32'(dut.registers0.regs[6]), 32'd0);
    check("restart_pc", 32'(dut.pc0.pc_out), 32'd1);

    @(negedge clk);
    set_pc(1023);
    run(1, "wrap");
    check("wrap_pc", 32'(dut.pc0.pc_out), 32'd0);

    // Random programs with a mid-run asynchronous reset.
    async_reset_check("rst_rand");
    for (int i = 0; i < 1024; i++) set_rom(i, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      int op;
      op = ($urandom_range(0, 99) < 10) ? int'($urandom_range(12, 127)) : int'($urandom_range(0, 11));
      if (op == 1) op = 2;
      set_rom(i, enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
      set_sram(i, 16'($urandom));
    end
    for (int i = 0; i < 8; i++)
      set_reg(i, ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 70)) : 16'($urandom));
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) async_reset_check("rst_mid");
      run(1, "rand");
    end
    for (int i = 0; i < 1024; i++)
      check($sformatf("sram%0d", i), 32'(dut.sram0.memory[i]), 32'(m_sram[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
